// File: rtl/cpu32_pkg.sv
// Shared cpu32 definitions: word width, default reset address, fetch FSM states.
package cpu32_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] CPU32_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_FULL    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch buffer with redirect/discard handling.
// Optional FETCH_PERF_EN adds perf_fetched, a count of decoder handshakes.
module fetch_unit
   import cpu32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = CPU32_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched
`endif
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] tgt;

   assign tgt = word_align(redirect_pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
      end else begin
         case (state)
            ST_REQ: begin
               // REQ with no request issued only happens on the first cycle after reset
               if (!imem_req) begin
                  imem_req <= 1'b1;
                  if (redirect) begin
                     pc        <= tgt;
                     imem_addr <= tgt;
                  end else begin
                     imem_addr <= pc;
                  end
               end else if (redirect) begin
                  pc <= tgt;
                  if (imem_ack) imem_addr <= tgt;
                  else          state     <= ST_DISCARD;
               end else if (imem_ack) begin
                  inst       <= imem_rdata;
                  inst_pc    <= imem_addr;
                  pc         <= imem_addr + 32'd4;
                  inst_valid <= 1'b1;
                  imem_req   <= 1'b0;
                  state      <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (redirect) begin
                  inst_valid <= 1'b0;
                  pc         <= tgt;
                  imem_req   <= 1'b1;
                  imem_addr  <= tgt;
                  state      <= ST_REQ;
               end else if (inst_ready) begin
                  inst_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  imem_addr  <= pc;
                  state      <= ST_REQ;
               end
            end
            ST_DISCARD: begin
               // old request stays on the bus; its data is dropped on ack
               if (imem_ack) begin
                  imem_addr <= redirect ? tgt : pc;
                  pc        <= redirect ? tgt : pc;
                  state     <= ST_REQ;
               end else if (redirect) begin
                  pc <= tgt;
               end
            end
            default: state <= ST_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       perf_fetched <= '0;
      else if (inst_valid && inst_ready) perf_fetched <= perf_fetched + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset-abandon sequence,
// and randomized traffic against an expected-instruction-stream model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
`endif

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ipc;
      logic        ack;
      logic        rdy;
      logic        rd;
      logic [31:0] rpc;
   } vec_t;

   function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic vld,
                               input logic [31:0] ipc, input logic ack, input logic rdy,
                               input logic rd, input logic [31:0] rpc);
      vec_t v;
      v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc;
      v.ack = ack; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
      return v;
   endfunction

   vec_t tbl[27];

   initial begin
      logic [31:0] exp_pc;
      logic        prev_req, prev_ack;
      logic [31:0] prev_addr;
      int          lat;
      int          hs_cnt;

      // expected outputs during the cycle | inputs driven for that cycle
      tbl[0]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
      tbl[1]  = mk(1, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0);
      tbl[2]  = mk(0, 32'h0,        1, 32'h0,        0, 1, 0, 32'h0);
      tbl[3]  = mk(1, 32'h4,        0, 32'h0,        1, 1, 0, 32'h0);
      tbl[4]  = mk(0, 32'h0,        1, 32'h4,        0, 1, 0, 32'h0);
      tbl[5]  = mk(1, 32'h8,        0, 32'h0,        1, 1, 0, 32'h0);
      for (int i = 6; i <= 10; i++)
         tbl[i] = mk(0, 32'h0,      1, 32'h8,        0, 0, 0, 32'h0);
      tbl[11] = mk(0, 32'h0,        1, 32'h8,        0, 1, 0, 32'h0);
      tbl[12] = mk(1, 32'hC,        0, 32'h0,        0, 1, 1, 32'h0000_0103);
      tbl[13] = mk(1, 32'hC,        0, 32'h0,        0, 1, 0, 32'h0);
      tbl[14] = mk(1, 32'hC,        0, 32'h0,        0, 1, 0, 32'h0);
      tbl[15] = mk(1, 32'hC,        0, 32'h0,        1, 1, 0, 32'h0);
      tbl[16] = mk(1, 32'h100,      0, 32'h0,        1, 1, 0, 32'h0);
      tbl[17] = mk(0, 32'h0,        1, 32'h100,      0, 1, 1, 32'h300);
      tbl[18] = mk(1, 32'h300,      0, 32'h0,        0, 1, 1, 32'h40);
      tbl[19] = mk(1, 32'h300,      0, 32'h0,        0, 1, 1, 32'h80);
      tbl[20] = mk(1, 32'h300,      0, 32'h0,        1, 1, 0, 32'h0);
      tbl[21] = mk(1, 32'h80,       0, 32'h0,        1, 1, 0, 32'h0);
      tbl[22] = mk(0, 32'h0,        1, 32'h80,       0, 1, 0, 32'h0);
      tbl[23] = mk(1, 32'h84,       0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC);
      tbl[24] = mk(1, 32'hFFFF_FFFC,0, 32'h0,        1, 1, 0, 32'h0);
      tbl[25] = mk(0, 32'h0,        1, 32'hFFFF_FFFC,0, 1, 0, 32'h0);
      tbl[26] = mk(1, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      repeat (2) @(negedge clk);
      chk("rst_req",    {31'b0, imem_req},   32'd0);
      chk("rst_addr",   imem_addr,           32'h0);
      chk("rst_valid",  {31'b0, inst_valid}, 32'd0);
      chk("rst_inst",   inst,                32'h0);
      chk("rst_instpc", inst_pc,             32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf",   perf_fetched,        32'h0);
`endif
      rst_n = 1'b1;

      // directed table
      for (int k = 0; k < 27; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("t%0d_req", k),   {31'b0, imem_req},   {31'b0, tbl[k].req});
         if (tbl[k].req) chk($sformatf("t%0d_addr", k), imem_addr, tbl[k].addr);
         chk($sformatf("t%0d_valid", k), {31'b0, inst_valid}, {31'b0, tbl[k].vld});
         if (tbl[k].vld) begin
            chk($sformatf("t%0d_instpc", k), inst_pc, tbl[k].ipc);
            chk($sformatf("t%0d_inst", k),   inst,    mem(tbl[k].ipc));
         end
         imem_ack    = tbl[k].ack;
         imem_rdata  = mem(imem_addr);
         inst_ready  = tbl[k].rdy;
         redirect    = tbl[k].rd;
         redirect_pc = tbl[k].rpc;
      end

      // reset while a request is outstanding: abandoned immediately
      @(negedge clk);
      imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
      chk("tbl_perf", perf_fetched, 32'd6);
`endif
      chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",   {31'b0, imem_req},   32'd0);
      chk("mid_rst_addr",  imem_addr,           32'h0);
      chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("mid_rst_inst",  inst,                32'h0);
      @(negedge clk);
      chk("hold_rst_req",  {31'b0, imem_req},   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_req",  {31'b0, imem_req},   32'd1);
      chk("post_rst_addr", imem_addr,           32'h0);

      // randomized traffic; model = expected stream of fetch addresses
      exp_pc = 32'h0; hs_cnt = 0; lat = $urandom_range(0, 3);
      prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("excl", {31'b0, inst_valid && imem_req}, 32'd0);
         if (imem_req) chk("align", {30'b0, imem_addr[1:0]}, 32'd0);
         if (prev_req && !prev_ack) begin
            chk("hold_req",  {31'b0, imem_req}, 32'd1);
            chk("hold_addr", imem_addr, prev_addr);
         end
         imem_ack = 1'b0;
         if (imem_req) begin
            if (lat == 0) begin
               imem_ack = 1'b1;
               lat = $urandom_range(0, 3);
            end else lat--;
         end
         imem_rdata  = imem_ack ? mem(imem_addr) : $urandom;
         inst_ready  = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
         if (inst_valid && inst_ready) begin
            chk("rnd_instpc", inst_pc, exp_pc);
            chk("rnd_inst",   inst,    mem(exp_pc));
            exp_pc = exp_pc + 32'd4;
            hs_cnt++;
         end
         if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      end
      @(negedge clk);
      redirect = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0;
      chk("progress", {31'b0, hs_cnt > 200}, 32'd1);
`ifdef FETCH_PERF_EN
      chk("rnd_perf", perf_fetched, hs_cnt);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
